// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: ALU opcodes, sequencer
// FSM states and the command word stored in the command FIFO.
package alu_seq_pkg;

  // Widest tag the command word can carry; the top uses the low TAG_W bits.
  localparam int unsigned TAG_W_MAX = 8;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    XOR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [3:0]           a;
    logic [3:0]           b;
    op_t                  op;
    logic [TAG_W_MAX-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Bus bundle for the ALU command sequencer: command channel in, ALU
// drive/return signals, and the response channel back to the requester.
// The sequencer uses the slave view; a requester/ALU model uses master.
interface alu_cmd_seq_if #(
  parameter int TAG_W = 2
);

  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  // ALU side
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_sel;
  logic             alu_start;
  logic [3:0]       alu_result;
  logic             alu_ready;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_sel, alu_start,
    input  alu_result, alu_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel, alu_start,
    output alu_result, alu_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Small first-word-fall-through FIFO holding queued ALU commands.
// dout always shows the head entry; it is only meaningful while !empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of the sequential 4-bit ALU. Queues requests,
// issues them to the ALU one at a time with a single-cycle start pulse,
// waits for the ALU done pulse (bounded by a watchdog) and hands the result
// back on a valid/ready response channel.
module alu_cmd_seq
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  alu_cmd_seq_if.slave bus
);

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  localparam logic [7:0] WD_MAX   = 8'hFF;

  seq_state_t       state;
  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [1:0]       alu_sel_q;
  logic             alu_start_q;
  logic [TAG_W-1:0] tag_q;

  logic [7:0]       wd;
  logic [7:0]       wd_inc;
  logic             wd_hit;
  logic             alu_done;
  logic             wd_expire;

  logic             rsp_valid_q;
  logic [3:0]       rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  // Tag bits above TAG_W are pushed as zero and never read back.
  logic             unused_tag;

  // Pack the incoming command; unused upper tag bits stay zero.
  always_comb begin
    push_cmd                 = '0;
    push_cmd.a               = bus.cmd_a;
    push_cmd.b               = bus.cmd_b;
    push_cmd.op              = op_t'(bus.cmd_op);
    push_cmd.tag[TAG_W-1:0]  = bus.cmd_tag;
  end

  // cmd_ready deliberately ignores a same-cycle pop so it stays a simple
  // decode of registered occupancy.
  assign bus.cmd_ready = ~fifo_full;
  assign fifo_push     = bus.cmd_valid & ~fifo_full;

  // A new command is taken from the head either from IDLE or directly out
  // of RESP in the cycle the response is accepted.
  assign fifo_pop = ~fifo_empty &
                    ((state == IDLE) | ((state == RESP) & bus.rsp_ready));

  assign wd_inc    = (wd == WD_MAX) ? wd : wd + 8'd1;
  assign wd_hit    = (wd_inc == WD_LIMIT);
  assign alu_done  = (state == WAIT) & bus.alu_ready;
  assign wd_expire = (state == WAIT) & ~bus.alu_ready & wd_hit;

  assign unused_tag = ^head_cmd.tag;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_cmd),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer FSM: IDLE -> ISSUE -> WAIT -> RESP, chaining straight from
  // RESP to ISSUE when more work is queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (fifo_pop) state <= ISSUE;
        ISSUE:   state <= WAIT;
        WAIT:    if (alu_done || wd_expire) state <= RESP;
        RESP:    if (bus.rsp_ready) state <= fifo_pop ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operands and tag change only on the edge that enters ISSUE, so they are
  // stable from the start pulse through the ALU done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      tag_q     <= '0;
    end else if (fifo_pop) begin
      alu_a_q   <= head_cmd.a;
      alu_b_q   <= head_cmd.b;
      alu_sel_q <= head_cmd.op;
      tag_q     <= head_cmd.tag[TAG_W-1:0];
    end
  end

  // Start pulse is the registered pop, which makes it exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_start_q <= 1'b0;
    end else begin
      alu_start_q <= fifo_pop;
    end
  end

  // Watchdog: cleared in ISSUE, counts WAIT cycles, saturates at 8 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= '0;
    end else if (state == ISSUE) begin
      wd <= '0;
    end else if (state == WAIT) begin
      wd <= wd_inc;
    end
  end

  // Response registers: loaded on completion or timeout, held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else if (alu_done) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= bus.alu_result;
      rsp_tag_q   <= tag_q;
      rsp_err_q   <= 1'b0;
    end else if (wd_expire) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= '0;
      rsp_tag_q   <= tag_q;
      rsp_err_q   <= 1'b1;
    end else if ((state == RESP) && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_start = alu_start_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;

  // The start pulse must never appear outside ISSUE.
  a_start_in_issue: assert property (
    @(posedge clk) disable iff (!rst) alu_start_q |-> (state == ISSUE)
  );

endmodule
